pe_scheduler: RTL and testbench
===============================

# pe_scheduler

Sequencing controller for the PE array (MESH_N meshes feeding a parameterised adder tree). For one convolution layer it walks every (input-channel tile, output channel) pair, drives buffer read addresses and the PE `ena`/`data_valid` strobes, and steers the `inter_data` partial-sum path. It tracks each issue through the PE pipeline to write back partial sums, and presents finished output channels on a valid/ready port. Downstream backpressure freezes the whole PE pipeline through `ena`.

## Interface
- CNT_W, 10, width of tile/channel counters and buffer addresses
- PIPE_LAT, 8, PE latency in enabled cycles from issue to result at `data_out`; must be ≥2

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a layer; sampled only in IDLE
- cfg_in_tiles  in  CNT_W  number of input tiles T (each tile is MESH_N channels)
- cfg_out_ch  in  CNT_W  number of output channels OC
- busy  out  1  high from start acceptance until DONE is left
- done  out  1  one-cycle pulse when the layer completes
- pe_ena  out  1  PE pipeline clock enable
- pe_data_valid  out  1  issue strobe, aligned with the buffer addresses
- fbuf_rd_addr  out  CNT_W  feature tile index t
- wbuf_rd_addr  out  2*CNT_W  weight address t*OC+oc
- psum_rd_addr  out  CNT_W  oc whose partial sum feeds `inter_data`
- inter_zero  out  1  1 selects zero for `inter_data` (first tile)
- psum_wr_en  out  1  write the PE result to the partial-sum buffer
- psum_wr_addr  out  CNT_W  oc of the result being written
- out_valid  out  1  final result for `out_oc` is on the PE `data_out`
- out_oc  out  CNT_W  output-channel index of the final result
- out_ready  in  1  downstream accepts the result

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: if `start` is high, latch cfg. If T==0 or OC==0, go to DONE. Otherwise go to RUN with t=0 and oc=0.
- RUN: every enabled cycle issues one slot.
  - Real issue: `pe_data_valid`=1. Addresses reflect the current (t, oc). Then oc increments; on oc==OC-1, oc wraps to 0 and t increments.
  - Round-end bubbles: if OC<PIPE_LAT, insert PIPE_LAT−OC bubble slots (`pe_data_valid`=0) after each round with t<T−1. This ensures the partial sum for (oc, t−1) has been written before (oc, t) needs it.
  - After issuing (OC−1, T−1), go to DRAIN.
- Tag pipeline: PIPE_LAT stages of {valid, first=(t==0), last=(t==T−1), oc}. It advances only when `pe_ena`=1.
  - Stage PIPE_LAT−1 tag drives `psum_rd_addr` and `inter_zero` (valid&first). When the stage is invalid, `inter_zero`=0 and `psum_rd_addr` holds.
  - Exit stage with !last drives `psum_wr_en`=valid and `psum_wr_addr`=oc.
  - Exit stage with last drives `out_valid`=valid and `out_oc`=oc; no psum write.
- DRAIN: issue bubbles until all tags have exited and the final `out_valid` handshake completes, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. `busy` is 0 in IDLE only.
- `pe_ena` = !(out_valid & !out_ready). This freezes counters, tags, addresses and the FSM. `psum_wr_en` is gated by `pe_ena`.
- `start` outside IDLE is ignored. cfg changes after acceptance are ignored.

## Timing
- Reset: state IDLE. Counters and tags cleared. All outputs 0 except `pe_ena`=1.
- Start sampled in cycle N gives the first issue in cycle N+1.
- Issue (oc, t) at enabled cycle k produces its result at exit in enabled cycle k+PIPE_LAT. `inter_zero`/`psum_rd_addr` for that result are presented at k+PIPE_LAT−1.
- Total enabled cycles from first issue to `done`: T·OC + (T−1)·max(0, PIPE_LAT−OC) + PIPE_LAT + 1.
- `out_valid` is held with `out_oc` stable until `out_ready`. A transfer occurs on `out_valid & out_ready`.
- Reset asserted mid-layer returns the block to IDLE immediately. No `done` is pulsed.

## Test plan
- T=1, OC=3, PIPE_LAT=8, out_ready=1: 3 issues, each with `inter_zero`=1 at its tap. `out_oc` = 0,1,2 on consecutive cycles; no `psum_wr_en`; `done` 12 cycles after first issue.
- T=3, OC=10: `wbuf_rd_addr` runs 0..29 with no bubbles. 20 psum writes (t=0,1), then 10 `out_valid` pulses. For t≥1, `psum_rd_addr` equals the oc written ≥1 cycle earlier.
- T=2, OC=2, PIPE_LAT=8: 6 bubbles between the rounds. Each tile-1 read occurs after the matching tile-0 write; total 4+6+8+1=19 cycles.
- Backpressure: hold out_ready=0 for 5 cycles at the first `out_valid`. `pe_ena`=0 and all addresses and tags are frozen for 5 cycles. No result is lost or duplicated.
- T=0 or OC=0 with start: busy for exactly 1 cycle, `done` pulse, zero issues.
- Assert rst_n low mid-RUN, then restart with T=2, OC=9: outputs are 0 during reset, and the second run's sequence is identical to a clean run.

Source files
------------

// File: rtl/pe_scheduler.sv
// pe_scheduler: walks every (input tile, output channel) pair of one layer,
// drives the PE issue strobes and buffer addresses, follows each issue through
// the PE pipeline with a tag, and hands finished output channels downstream.
module pe_scheduler #(
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned PIPE_LAT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cfg_in_tiles,
    input  logic [CNT_W-1:0]     cfg_out_ch,
    output logic                 busy,
    output logic                 done,
    output logic                 pe_ena,
    output logic                 pe_data_valid,
    output logic [CNT_W-1:0]     fbuf_rd_addr,
    output logic [2*CNT_W-1:0]   wbuf_rd_addr,
    output logic [CNT_W-1:0]     psum_rd_addr,
    output logic                 inter_zero,
    output logic                 psum_wr_en,
    output logic [CNT_W-1:0]     psum_wr_addr,
    output logic                 out_valid,
    output logic [CNT_W-1:0]     out_oc,
    input  logic                 out_ready
);

    localparam int unsigned WA_W     = 2 * CNT_W;
    localparam int unsigned TAP_IDX  = PIPE_LAT - 2;
    localparam int unsigned EXIT_IDX = PIPE_LAT - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             first;
        logic             last;
        logic [CNT_W-1:0] oc;
    } tag_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  t_q, t_d;
    logic [CNT_W-1:0]  oc_q, oc_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic [CNT_W-1:0]  bub_q, bub_d;
    logic [CNT_W-1:0]  cfg_t_q, cfg_t_d;
    logic [CNT_W-1:0]  cfg_oc_q, cfg_oc_d;
    logic [CNT_W-1:0]  rd_hold_q;
    tag_t              tag_q [PIPE_LAT];
    tag_t              issue_tag;
    tag_t              tap_tag;
    tag_t              exit_tag;
    logic              pipe_busy;
    logic [CNT_W-1:0]  last_t;
    logic [CNT_W-1:0]  last_oc;

    assign tap_tag  = tag_q[TAP_IDX];
    assign exit_tag = tag_q[EXIT_IDX];
    assign last_t   = cfg_t_q - CNT_W'(1);
    assign last_oc  = cfg_oc_q - CNT_W'(1);

    // Result/handshake side: the exit stage decides between psum write and final output.
    assign out_valid    = exit_tag.valid & exit_tag.last;
    assign out_oc       = exit_tag.oc;
    assign pe_ena       = ~(out_valid & ~out_ready);
    assign psum_wr_en   = exit_tag.valid & ~exit_tag.last & pe_ena;
    assign psum_wr_addr = exit_tag.oc;

    // Partial-sum read tap, one stage ahead of the exit; holds its address when idle.
    assign inter_zero   = tap_tag.valid & tap_tag.first;
    assign psum_rd_addr = tap_tag.valid ? tap_tag.oc : rd_hold_q;

    // Issue side decoded from the walk counters.
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign pe_data_valid = (state_q == S_RUN) && (bub_q == '0);
    assign fbuf_rd_addr  = t_q;
    assign wbuf_rd_addr  = waddr_q;

    // Any tag still in flight ahead of the exit stage.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < int'(EXIT_IDX); i++) begin
            pipe_busy = pipe_busy | tag_q[i].valid;
        end
    end

    // Next-state logic: layer walk, round-end bubbles and drain.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        oc_d      = oc_q;
        waddr_d   = waddr_q;
        bub_d     = bub_q;
        cfg_t_d   = cfg_t_q;
        cfg_oc_d  = cfg_oc_q;
        issue_tag = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_t_d  = cfg_in_tiles;
                    cfg_oc_d = cfg_out_ch;
                    t_d      = '0;
                    oc_d     = '0;
                    waddr_d  = '0;
                    bub_d    = '0;
                    if ((cfg_in_tiles == '0) || (cfg_out_ch == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bub_q != '0) begin
                    bub_d = bub_q - CNT_W'(1);
                end else begin
                    issue_tag.valid = 1'b1;
                    issue_tag.first = (t_q == '0);
                    issue_tag.last  = (t_q == last_t);
                    issue_tag.oc    = oc_q;
                    waddr_d         = waddr_q + WA_W'(1);
                    if (oc_q == last_oc) begin
                        oc_d = '0;
                        if (t_q == last_t) begin
                            state_d = S_DRAIN;
                            t_d     = '0;
                            waddr_d = '0;
                        end else begin
                            // Space rounds so a tile never reads a psum not yet written.
                            t_d   = t_q + CNT_W'(1);
                            bub_d = (cfg_oc_q < CNT_W'(PIPE_LAT)) ?
                                    (CNT_W'(PIPE_LAT) - cfg_oc_q) : '0;
                        end
                    end else begin
                        oc_d = oc_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!pipe_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; everything freezes while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            oc_q     <= '0;
            waddr_q  <= '0;
            bub_q    <= '0;
            cfg_t_q  <= '0;
            cfg_oc_q <= '0;
        end else if (pe_ena) begin
            state_q  <= state_d;
            t_q      <= t_d;
            oc_q     <= oc_d;
            waddr_q  <= waddr_d;
            bub_q    <= bub_d;
            cfg_t_q  <= cfg_t_d;
            cfg_oc_q <= cfg_oc_d;
        end
    end

    // Tag pipeline mirroring the PE latency, plus the held read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                tag_q[i] <= '0;
            end
            rd_hold_q <= '0;
        end else if (pe_ena) begin
            tag_q[0] <= issue_tag;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (tap_tag.valid) begin
                rd_hold_q <= tap_tag.oc;
            end
        end
    end

endmodule

// File: tb/tb_pe_scheduler.sv
// Scoreboard bench for pe_scheduler: expected issues and exits are queued per
// layer, a negedge monitor pops and compares them as the DUT presents them.
module tb_pe_scheduler;

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned PIPE_LAT = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [CNT_W-1:0]     cfg_in_tiles;
    logic [CNT_W-1:0]     cfg_out_ch;
    logic                 busy;
    logic                 done;
    logic                 pe_ena;
    logic                 pe_data_valid;
    logic [CNT_W-1:0]     fbuf_rd_addr;
    logic [2*CNT_W-1:0]   wbuf_rd_addr;
    logic [CNT_W-1:0]     psum_rd_addr;
    logic                 inter_zero;
    logic                 psum_wr_en;
    logic [CNT_W-1:0]     psum_wr_addr;
    logic                 out_valid;
    logic [CNT_W-1:0]     out_oc;
    logic                 out_ready;

    pe_scheduler #(.CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_in_tiles  (cfg_in_tiles),
        .cfg_out_ch    (cfg_out_ch),
        .busy          (busy),
        .done          (done),
        .pe_ena        (pe_ena),
        .pe_data_valid (pe_data_valid),
        .fbuf_rd_addr  (fbuf_rd_addr),
        .wbuf_rd_addr  (wbuf_rd_addr),
        .psum_rd_addr  (psum_rd_addr),
        .inter_zero    (inter_zero),
        .psum_wr_en    (psum_wr_en),
        .psum_wr_addr  (psum_wr_addr),
        .out_valid     (out_valid),
        .out_oc        (out_oc),
        .out_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int t; int oc; int wa; } iss_t;
    typedef struct { int t; int oc; bit first; bit last; } ext_t;

    iss_t iss_q[$];
    ext_t ext_q[$];

    int   n_checks;
    int   n_errors;
    bit   mon_en;
    bit   seen_first;
    int   ecnt;
    int   done_ecnt;
    int   done_cnt;
    int   bub_cnt;
    int   busy_cnt;
    int   wr_cnt [16];
    int   wr_cyc [16];
    logic             prev_iz;
    logic [CNT_W-1:0] prev_rd;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_pe_ena"}, int'(pe_ena), 1);
        check({name, "_ctrl"}, int'({busy, done, pe_data_valid, inter_zero, psum_wr_en, out_valid}), 0);
        check({name, "_addr"}, int'(fbuf_rd_addr) + int'(wbuf_rd_addr) + int'(psum_rd_addr)
                               + int'(psum_wr_addr) + int'(out_oc), 0);
    endtask

    // Monitor: pops expected issues/exits and checks tap and read-after-write order.
    always @(negedge clk) begin
        iss_t it;
        ext_t et;
        if (mon_en && rst_n) begin
            if (busy) busy_cnt++;
            if (pe_ena) begin
                if (pe_data_valid && !seen_first) seen_first = 1'b1;
                if (seen_first) ecnt++;
                if (pe_data_valid) begin
                    if (iss_q.size() == 0) begin
                        check("issue_extra", 1, 0);
                    end else begin
                        it = iss_q.pop_front();
                        check("fbuf_rd_addr", int'(fbuf_rd_addr), it.t);
                        check("wbuf_rd_addr", int'(wbuf_rd_addr), it.wa);
                    end
                end else if (seen_first && iss_q.size() != 0) begin
                    bub_cnt++;
                end
                if (psum_wr_en || (out_valid && out_ready)) begin
                    if (ext_q.size() == 0) begin
                        check("exit_extra", 1, 0);
                    end else begin
                        et = ext_q.pop_front();
                        check("exit_is_final", int'(out_valid), int'(et.last));
                        if (out_valid) check("out_oc", int'(out_oc), et.oc);
                        else           check("psum_wr_addr", int'(psum_wr_addr), et.oc);
                        check("tap_inter_zero", int'(prev_iz), int'(et.first));
                        check("tap_psum_rd_addr", int'(prev_rd), et.oc);
                        if (!et.first) begin
                            check("raw_write_count", wr_cnt[et.oc], et.t);
                            check("raw_write_before_read", int'(wr_cyc[et.oc] < ecnt - 1), 1);
                        end
                        if (psum_wr_en) begin
                            wr_cnt[et.oc]++;
                            wr_cyc[et.oc] = ecnt;
                        end
                    end
                end
                prev_iz = inter_zero;
                prev_rd = psum_rd_addr;
            end
            if (done) begin
                done_cnt++;
                done_ecnt = ecnt;
            end
        end
    end

    task automatic load_layer(input int tn, input int ocn);
        iss_q.delete();
        ext_q.delete();
        for (int t = 0; t < tn; t++) begin
            for (int oc = 0; oc < ocn; oc++) begin
                iss_q.push_back('{t: t, oc: oc, wa: t * ocn + oc});
                ext_q.push_back('{t: t, oc: oc, first: (t == 0), last: (t == tn - 1)});
            end
        end
        seen_first = 1'b0;
        ecnt       = 0;
        done_ecnt  = -1;
        done_cnt   = 0;
        bub_cnt    = 0;
        busy_cnt   = 0;
        for (int i = 0; i < 16; i++) begin
            wr_cnt[i] = 0;
            wr_cyc[i] = -100;
        end
    endtask

    task automatic issue_start(input int tn, input int ocn);
        @(posedge clk); #1;
        start        = 1'b1;
        cfg_in_tiles = CNT_W'(tn);
        cfg_out_ch   = CNT_W'(ocn);
        @(posedge clk); #1;
        start        = 1'b0;
        cfg_in_tiles = CNT_W'(5);
        cfg_out_ch   = CNT_W'(7);
    endtask

    // Stall the first final result for 5 cycles and verify everything freezes.
    task automatic bp_proc();
        logic [CNT_W-1:0]   f0, r0, o0;
        logic [2*CNT_W-1:0] w0;
        logic               z0;
        bit                 got;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(posedge clk); #1;
            if (out_valid) got = 1'b1;
        end
        check("bp_out_valid_seen", int'(got), 1);
        if (got) begin
            out_ready = 1'b0;
            f0 = fbuf_rd_addr; w0 = wbuf_rd_addr; r0 = psum_rd_addr;
            o0 = out_oc; z0 = inter_zero;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check("bp_pe_ena_low", int'(pe_ena), 0);
                check("bp_out_valid_held", int'(out_valid), 1);
                check("bp_frozen", int'(fbuf_rd_addr != f0) + int'(wbuf_rd_addr != w0)
                                   + int'(psum_rd_addr != r0) + int'(out_oc != o0)
                                   + int'(inter_zero != z0) + int'(psum_wr_en), 0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
    endtask

    task automatic run_layer(input int tn, input int ocn, input int exp_cyc,
                             input int exp_bub, input int exp_busy, input bit bp);
        bit active;
        active = (tn > 0) && (ocn > 0);
        load_layer(tn, ocn);
        mon_en = 1'b1;
        issue_start(tn, ocn);
        @(negedge clk);
        check("busy_after_start", int'(busy), 1);
        check("first_slot_issue", int'(pe_data_valid), int'(active));
        if (active && !bp) begin
            // A start pulse while running must be ignored.
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        if (bp) begin
            fork
                bp_proc();
                wait_done();
            join
        end else begin
            wait_done();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("enabled_cycles_to_done", done_ecnt, exp_cyc);
        check("bubble_slots", bub_cnt, exp_bub);
        check("busy_cycles", busy_cnt, exp_busy);
        check("issues_missing", iss_q.size(), 0);
        check("exits_missing", ext_q.size(), 0);
        check("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        int dc;
        n_checks     = 0;
        n_errors     = 0;
        mon_en       = 1'b0;
        rst_n        = 1'b0;
        start        = 1'b0;
        cfg_in_tiles = '0;
        cfg_out_ch   = '0;
        out_ready    = 1'b1;
        prev_iz      = 1'b0;
        prev_rd      = '0;
        #1;
        check_reset_outputs("reset_state");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_layer(1, 3, 12, 0, 12, 1'b0);
        run_layer(3, 10, 39, 0, 39, 1'b0);
        run_layer(2, 2, 19, 6, 19, 1'b0);
        run_layer(2, 3, 20, 5, 25, 1'b1);
        run_layer(0, 5, 0, 0, 1, 1'b0);
        run_layer(2, 0, 0, 0, 1, 1'b0);

        // Reset in the middle of a layer, then a clean layer afterwards.
        load_layer(3, 10);
        mon_en = 1'b0;
        issue_start(3, 10);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("midrun_busy_before_reset", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        dc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("midrun_reset_no_done", dc, 0);
        check_reset_outputs("midrun_reset_held");
        rst_n = 1'b1;
        run_layer(2, 9, 27, 0, 27, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
